uart_tx_ctrl: RTL and testbench
===============================

# uart_tx_ctrl

UART transmit controller that turns a one-cycle byte request into a framed serial bit stream on the TX line. Serial frame is start bit, 8 data bits (LSB first), optional parity bit, stop bit. The block sequences a baud-tick counter and a bit-index counter. It sits between the byte-level producer logic and the FPGA TX pin.

## Interface
Parameters:
- INPUT_CLOCK_FREQ, 100_000_000: clk_in frequency in Hz.
- BAUD_RATE, 9600: serial bit rate in bits/s.
- Derived localparam CYCLES_PER_BIT = INPUT_CLOCK_FREQ / BAUD_RATE, truncated. Elaboration `$error` if < 2.

Ports:
- clk_in  input  1  system clock; the only clock.
- rst_in  input  1  reset, asynchronous, active-low.
- data_byte_in  input  8  byte to send; sampled only when accepted.
- trigger_in  input  1  send request; accepted at a rising edge where busy_out == 0.
- busy_out  output  1  high from the acceptance edge until the frame completes.
- done_out  output  1  one-cycle pulse marking frame completion.
- tx_wire_out  output  1  serial line, registered, idle high.

## Operation
- State enum: IDLE, START, DATA, PARITY (only with the macro), STOP.
- **IDLE:**
  - tx_wire_out = 1.
  - On trigger_in: latch data_byte_in, clear the baud and bit counters, go to START.
- **Baud counter:** counts 0..CYCLES_PER_BIT-1. A terminal count (tc) occurs when it equals CYCLES_PER_BIT-1; it then wraps to 0. It is held at 0 in IDLE.
- **START:** tx = 0. On tc go to DATA.
- **DATA:**
  - tx = latched_byte[bit_idx].
  - On tc: bit_idx increments.
  - When bit_idx == 7 and tc: go to PARITY if enabled, else STOP.
- **PARITY:** tx = even parity (XOR of the latched byte). On tc go to STOP.
- **STOP:** tx = 1. On tc go to IDLE and pulse done_out.
- **trigger_in while busy:** ignored. No queueing, and the latched byte is unchanged.
- **data_byte_in after acceptance:** changes have no effect.
- **Reset (asynchronous):**
  - state = IDLE, tx_wire_out = 1, busy_out = 0, done_out = 0.
  - Counters = 0, latched byte = 0.
  - Reset mid-frame aborts immediately. The line returns high with no done pulse.

## Timing
- Let the acceptance edge be k and N = CYCLES_PER_BIT.
- tx_wire_out and busy_out change after edge k. Zero-cycle latency from the request edge to the start bit appearing.
- Bit j (start = 0) is driven from edge k+jN to edge k+(j+1)N. Every bit is exactly N cycles, stop bit included.
- Frame length is F = 10N, or 11N with parity. At edge k+F:
  - state = IDLE;
  - busy_out falls;
  - done_out is high for the one cycle following that edge.
- A trigger during the done cycle is accepted at edge k+F+1. Minimum frame-to-frame period is F+1 cycles, which gives a 1-cycle idle line gap.
- Counter widths:
  - baud counter: $clog2(N) bits;
  - bit index: 3 bits.
  - No overflow is possible because comparisons are against terminal values.

## Configuration
- UART_TX_PARITY_EN:
  - Defined: PARITY state is compiled in, an even parity bit goes between D7 and STOP, and F = 11N.
  - Undefined: no PARITY state, DATA goes directly to STOP, and F = 10N.

## Structure
- Package uart_pkg holds:
  - the tx_state_t enum;
  - localparam DATA_BITS = 8;
  - a function computing CYCLES_PER_BIT from the frequency and baud rate.
- One sub-module, uart_baud_counter. It is a modulo-N event counter with clk_in and rst_in (active-low async), a clear input, and a tc output. It is instantiated once.
- Bit sequencing and output registers live in uart_tx_ctrl.

## Test plan
All scenarios use INPUT_CLOCK_FREQ = 1_000_000 and BAUD_RATE = 100_000, so N = 10.
1. **Basic frame.** Reset low 20 cycles, release, then pulse trigger_in with byte 0x55. Required: line holds start 0, then 1,0,1,0,1,0,1,0, then stop 1, 10 cycles each. busy_out is high for 100 cycles. done_out pulses once at cycle 100.
2. **Busy rejection.** Send 0xA3, then pulse trigger_in with 0xFF at cycle 40. Required: the frame still carries 0xA3 and busy_out stays high exactly 100 cycles.
3. **Back-to-back.** Hold trigger_in high continuously with 0x0F. Required: consecutive frames have exactly 1 idle-high cycle between stop and next start, and done_out pulses every 101 cycles.
4. **Reset mid-frame.** Drive rst_in low at cycle 35 of a 0x00 frame. Required: tx_wire_out goes to 1 and busy_out to 0 asynchronously, with no done pulse. A new trigger after release sends a full correct frame.
5. **Parity (UART_TX_PARITY_EN defined).**
   - 0x07: parity bit 1; frame is 110 cycles and done_out pulses at cycle 110.
   - 0x03: parity bit 0.
6. **Idle after reset.** No trigger for 500 cycles. Required: tx_wire_out = 1, busy_out = 0, done_out = 0 throughout.

Source files
------------

// File: rtl/uart_pkg.sv
// ============================================================================
// Module      : uart_pkg
// Description : Shared types, constants and helpers for the UART transmitter.
//               The optional PARITY state exists only when UART_TX_PARITY_EN
//               is defined.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

package uart_pkg;

  localparam int DATA_BITS = 8;

  // Transmit sequencer states; PARITY only exists in the parity build.
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
    PARITY = 3'd3,
`endif
    STOP   = 3'd4
  } tx_state_t;

  // Clock cycles per serial bit, truncated; zero baud yields 0 so the
  // caller's range check reports the problem instead of a divide error.
  function automatic int calc_cycles_per_bit(input int freq_hz, input int baud);
    if (baud <= 0) begin
      return 0;
    end
    return freq_hz / baud;
  endfunction

endpackage

`default_nettype wire

// File: rtl/uart_baud_counter.sv
// ============================================================================
// Module      : uart_baud_counter
// Description : Modulo-N event counter. tc_out is high for the cycle in which
//               the count equals N-1; the counter then wraps to 0. clear_in
//               holds the count at 0 and suppresses tc_out.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module uart_baud_counter #(
  parameter int N = 10
) (
  input  logic clk_in,
  input  logic rst_in,
  input  logic clear_in,
  output logic tc_out
);

  // Width kept legal even for an out-of-range N so the parent's check fires.
  localparam int          W      = (N < 2) ? 1 : $clog2(N);
  localparam logic [W-1:0] C_LAST = W'(N - 1);

  logic [W-1:0] r_cnt;

  // Terminal count is a compare against the last value, so no overflow.
  assign tc_out = !clear_in && (r_cnt == C_LAST);

  // Count up, wrapping on terminal count; held at zero while cleared.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_cnt <= '0;
    end else if (clear_in || tc_out) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + W'(1);
    end
  end

endmodule

`default_nettype wire

// File: rtl/uart_tx_ctrl.sv
// ============================================================================
// Module      : uart_tx_ctrl
// Description : UART transmit controller. Accepts a byte on a trigger edge
//               while idle and shifts out start, 8 data bits (LSB first),
//               optional even parity, and stop, each CYCLES_PER_BIT cycles.
//               Optional feature macro: UART_TX_PARITY_EN (adds parity bit).
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module uart_tx_ctrl
  import uart_pkg::*;
#(
  parameter int INPUT_CLOCK_FREQ = 100_000_000,
  parameter int BAUD_RATE        = 9600
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic [DATA_BITS-1:0] data_byte_in,
  input  logic                 trigger_in,
  output logic                 busy_out,
  output logic                 done_out,
  output logic                 tx_wire_out
);

  localparam int CYCLES_PER_BIT = calc_cycles_per_bit(INPUT_CLOCK_FREQ, BAUD_RATE);
  localparam logic [2:0] LAST_BIT = 3'(DATA_BITS - 1);

  if (CYCLES_PER_BIT < 2) begin : g_cpb_check
    $error("uart_tx_ctrl: CYCLES_PER_BIT must be >= 2");
  end

  tx_state_t            r_state;
  tx_state_t            w_state_next;
  logic [2:0]           r_bit_idx;
  logic [2:0]           w_bit_idx_next;
  logic [DATA_BITS-1:0] r_byte;
  logic [DATA_BITS-1:0] w_byte_next;
  logic                 r_tx;
  logic                 w_tx_next;
  logic                 r_done;
  logic                 w_done_next;
  logic                 w_tc;
  logic                 w_baud_clear;

  // Baud counter idles at zero so the first bit period starts on acceptance.
  uart_baud_counter #(
    .N (CYCLES_PER_BIT)
  ) u_baud (
    .clk_in   (clk_in),
    .rst_in   (rst_in),
    .clear_in (w_baud_clear),
    .tc_out   (w_tc)
  );

  // Next-state, bit index, byte latch and done-pulse decisions.
  always_comb begin
    w_state_next   = r_state;
    w_bit_idx_next = r_bit_idx;
    w_byte_next    = r_byte;
    w_done_next    = 1'b0;
    w_baud_clear   = 1'b0;
    unique case (r_state)
      IDLE: begin
        w_baud_clear = 1'b1;
        if (trigger_in) begin
          w_byte_next    = data_byte_in;
          w_bit_idx_next = '0;
          w_state_next   = START;
        end
      end
      START: begin
        if (w_tc) begin
          w_state_next = DATA;
        end
      end
      DATA: begin
        if (w_tc) begin
          w_bit_idx_next = r_bit_idx + 3'd1;
          if (r_bit_idx == LAST_BIT) begin
`ifdef UART_TX_PARITY_EN
            w_state_next = PARITY;
`else
            w_state_next = STOP;
`endif
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (w_tc) begin
          w_state_next = STOP;
        end
      end
`endif
      STOP: begin
        if (w_tc) begin
          w_state_next = IDLE;
          w_done_next  = 1'b1;
        end
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  // Line level is derived from the upcoming state so the registered output
  // changes on the same edge as the state (start bit right at acceptance).
  always_comb begin
    w_tx_next = 1'b1;
    unique case (w_state_next)
      START:   w_tx_next = 1'b0;
      DATA:    w_tx_next = w_byte_next[w_bit_idx_next];
`ifdef UART_TX_PARITY_EN
      PARITY:  w_tx_next = ^w_byte_next;
`endif
      default: w_tx_next = 1'b1;
    endcase
  end

  // State, counters and output registers; reset aborts any frame at once.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_state   <= IDLE;
      r_bit_idx <= '0;
      r_byte    <= '0;
      r_tx      <= 1'b1;
      r_done    <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_bit_idx <= w_bit_idx_next;
      r_byte    <= w_byte_next;
      r_tx      <= w_tx_next;
      r_done    <= w_done_next;
    end
  end

  assign busy_out    = (r_state != IDLE);
  assign done_out    = r_done;
  assign tx_wire_out = r_tx;

endmodule

`default_nettype wire

// File: tb/tb_uart_tx_ctrl.sv
// ============================================================================
// Module      : tb_uart_tx_ctrl
// Description : Self-checking bench for uart_tx_ctrl with N = 10 cycles/bit.
//               Expected line levels come from a frame model built from the
//               bit layout. Honors UART_TX_PARITY_EN.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_uart_tx_ctrl;

  localparam int CLK_FREQ = 1_000_000;
  localparam int BAUD     = 100_000;
  localparam int N        = CLK_FREQ / BAUD;
`ifdef UART_TX_PARITY_EN
  localparam bit PAR = 1'b1;
  localparam int F   = 11 * N;
`else
  localparam bit PAR = 1'b0;
  localparam int F   = 10 * N;
`endif

  logic       clk_in = 1'b0;
  logic       rst_in = 1'b0;
  logic [7:0] data_byte_in = 8'h00;
  logic       trigger_in = 1'b0;
  logic       busy_out;
  logic       done_out;
  logic       tx_wire_out;

  int n_cmp  = 0;
  int n_fail = 0;
  int cyc    = 0;
  int done_cyc = 0;

  uart_tx_ctrl #(
    .INPUT_CLOCK_FREQ (CLK_FREQ),
    .BAUD_RATE        (BAUD)
  ) dut (
    .clk_in       (clk_in),
    .rst_in       (rst_in),
    .data_byte_in (data_byte_in),
    .trigger_in   (trigger_in),
    .busy_out     (busy_out),
    .done_out     (done_out),
    .tx_wire_out  (tx_wire_out)
  );

  always #5 clk_in = ~clk_in;

  always @(posedge clk_in) cyc <= cyc + 1;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  // Line level c cycles after acceptance: bit j = c / N of the frame
  // {start 0, D0..D7, [even parity], stop 1}.
  function automatic logic model_line(input logic [7:0] b, input int c);
    int j;
    j = c / N;
    if (j == 0) return 1'b0;
    if (j <= 8) return b[j-1];
    if (PAR && j == 9) return ^b;
    return 1'b1;
  endfunction

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic chk(input string tag, input logic obs, input logic exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic chk_int(input string tag, input int obs, input int exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_tx"},   tx_wire_out, 1'b1);
    chk({tag, "_busy"}, busy_out,    1'b0);
    chk({tag, "_done"}, done_out,    1'b0);
  endtask

  // Send one frame of byte b and check every cycle. poke_at: cycle at which
  // a busy-time trigger with 0xFF is issued; rnd_trig adds random triggers;
  // hold keeps trigger high; abort_at >= 0 asserts reset at that cycle.
  task automatic send_frame(input logic [7:0] b, input int poke_at,
                            input bit rnd_trig, input bit hold, input int abort_at);
    int t_acc;
    trigger_in   = 1'b1;
    data_byte_in = b;
    tick();
    t_acc = cyc;
    for (int c = 0; c < F; c++) begin
      if (c > 0) tick();
      if (c == abort_at) begin
        rst_in = 1'b0;
        #1;
        chk_idle("abort_async");
        trigger_in = 1'b0;
        return;
      end
      chk("frame_tx",   tx_wire_out, model_line(b, c));
      chk("frame_busy", busy_out,    1'b1);
      chk("frame_done", done_out,    1'b0);
      data_byte_in = 8'($urandom);
      trigger_in   = hold || (rnd_trig && ($urandom_range(0, 3) == 0));
      if (c == poke_at) begin
        trigger_in   = 1'b1;
        data_byte_in = 8'hFF;
      end
    end
    tick();
    chk("end_tx",   tx_wire_out, 1'b1);
    chk("end_busy", busy_out,    1'b0);
    chk("end_done", done_out,    1'b1);
    chk_int("frame_len", cyc - t_acc, F);
    done_cyc = cyc;
    trigger_in = hold;
  endtask

  initial begin
    int d1;
    logic [7:0] rb;

    // Reset held low for 20 cycles with activity on the inputs.
    for (int i = 0; i < 20; i++) begin
      trigger_in   = 1'($urandom);
      data_byte_in = 8'($urandom);
      tick();
      chk_idle("in_reset");
    end
    trigger_in = 1'b0;
    rst_in     = 1'b1;

    // Idle after reset: no trigger for 500 cycles.
    for (int i = 0; i < 500; i++) begin
      data_byte_in = 8'($urandom);
      tick();
      chk_idle("idle");
    end

    // Basic frame.
    send_frame(8'h55, -1, 1'b0, 1'b0, -1);
    tick();
    chk_idle("after_55");

    // Busy rejection: trigger with 0xFF at cycle 40.
    send_frame(8'hA3, 40, 1'b0, 1'b0, -1);
    tick();
    chk_idle("after_A3");

    // Back-to-back with trigger held high.
    send_frame(8'h0F, -1, 1'b0, 1'b1, -1);
    d1 = done_cyc;
    send_frame(8'h0F, -1, 1'b0, 1'b1, -1);
    chk_int("b2b_period", done_cyc - d1, F + 1);
    d1 = done_cyc;
    send_frame(8'h0F, -1, 1'b0, 1'b1, -1);
    chk_int("b2b_period2", done_cyc - d1, F + 1);
    trigger_in = 1'b0;
    tick();
    chk_idle("after_b2b");

    // Reset mid-frame at cycle 35, then a full frame after release.
    send_frame(8'h00, -1, 1'b0, 1'b0, 35);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk_idle("abort_hold");
    end
    rst_in = 1'b1;
    tick();
    chk_idle("abort_release");
    send_frame(8'h00, -1, 1'b0, 1'b0, -1);
    tick();
    chk_idle("after_abort");

    // Parity patterns (plain frames in the default build).
    send_frame(8'h07, -1, 1'b0, 1'b0, -1);
    tick();
    send_frame(8'h03, -1, 1'b0, 1'b0, -1);
    tick();

    // Random bytes with random triggers while busy.
    for (int i = 0; i < 8; i++) begin
      rb = 8'($urandom);
      send_frame(rb, -1, 1'b1, 1'b0, -1);
      trigger_in = 1'b0;
      tick();
      chk_idle("after_rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
